// File: rtl/key_loader_if.sv
// Serial key-load bus between a key source (master) and key_loader (slave).
interface key_loader_if;
    logic        key_start;
    logic        key_sdi;
    logic        key_sdi_vld;
    logic [3:0]  key_p;
    logic [13:0] key_x;
    logic        key_busy;
    logic        key_armed;
    logic        key_err;

    modport master (
        output key_start, key_sdi, key_sdi_vld,
        input  key_p, key_x, key_busy, key_armed, key_err
    );

    modport slave (
        input  key_start, key_sdi, key_sdi_vld,
        output key_p, key_x, key_busy, key_armed, key_err
    );
endinterface

// File: rtl/key_loader.sv
// Serial 18-bit key loader for the locked c432 netlist (key_x = K[17:4], key_p = K[3:0]).
// Define KEY_PARITY_EN to add the even-parity check, ERROR reporting and LOCKOUT.
module key_loader (
    input  logic         clk,
    input  logic         rst_n,
    key_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_ARMED   = 3'd2
`ifdef KEY_PARITY_EN
        ,
        ST_CHECK   = 3'd3,
        ST_ERROR   = 3'd4,
        ST_LOCKOUT = 3'd5
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [17:0] sr_q, sr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  key_p_q, key_p_d;
    logic [13:0] key_x_q, key_x_d;
    logic        busy_q, busy_d;
    logic        armed_q, armed_d;
    logic        start_ok;
`ifdef KEY_PARITY_EN
    logic [1:0]  fail_q, fail_d;
    logic        err_q, err_d;

    assign start_ok = bus.key_start && (state_q != ST_LOCKOUT);
`else
    assign start_ok = bus.key_start;
`endif

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block infers a latch.
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
`ifdef KEY_PARITY_EN
        fail_d  = fail_q;
`endif
        if (start_ok) begin
            // A start in the same cycle as a valid bit wins; that bit is dropped.
            state_d = ST_SHIFT;
            sr_d    = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (bus.key_sdi_vld) begin
                        sr_d  = {sr_q[16:0], bus.key_sdi};
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd17) begin
`ifdef KEY_PARITY_EN
                            state_d = ST_CHECK;
`else
                            state_d = ST_ARMED;
`endif
                        end
                    end
                end
`ifdef KEY_PARITY_EN
                ST_CHECK: begin
                    // Even parity over K and the trailing parity bit.
                    if (bus.key_sdi_vld) begin
                        if (^{sr_q, bus.key_sdi}) begin
                            if (fail_q == 2'd2) begin
                                state_d = ST_LOCKOUT;
                            end else begin
                                state_d = ST_ERROR;
                                fail_d  = fail_q + 2'd1;
                            end
                        end else begin
                            state_d = ST_ARMED;
                            fail_d  = '0;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end

        // Outputs are registered from the next state so they track the state register exactly.
        key_x_d = (state_d == ST_ARMED) ? sr_d[17:4] : '0;
        key_p_d = (state_d == ST_ARMED) ? sr_d[3:0]  : '0;
        armed_d = (state_d == ST_ARMED);
`ifdef KEY_PARITY_EN
        busy_d  = (state_d == ST_SHIFT) || (state_d == ST_CHECK);
        err_d   = (state_d == ST_ERROR) || (state_d == ST_LOCKOUT);
`else
        busy_d  = (state_d == ST_SHIFT);
`endif
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            key_p_q <= '0;
            key_x_q <= '0;
            busy_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            key_p_q <= key_p_d;
            key_x_q <= key_x_d;
            busy_q  <= busy_d;
            armed_q <= armed_d;
        end
    end

`ifdef KEY_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_q <= '0;
            err_q  <= 1'b0;
        end else begin
            fail_q <= fail_d;
            err_q  <= err_d;
        end
    end

    assign bus.key_err = err_q;
`else
    assign bus.key_err = 1'b0;
`endif

    assign bus.key_p     = key_p_q;
    assign bus.key_x     = key_x_q;
    assign bus.key_busy  = busy_q;
    assign bus.key_armed = armed_q;

endmodule

// File: tb/tb_key_loader.sv
// Self-checking bench for key_loader: directed cases plus random traffic against a bit-queue model.
// Follows KEY_PARITY_EN the same way the design does.
module tb_key_loader;

`ifdef KEY_PARITY_EN
    localparam bit PARITY_ON = 1'b1;
`else
    localparam bit PARITY_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    key_loader_if bus ();

    key_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: the bits received since the last start, plus outcome flags.
    bit          m_q[$];
    bit          m_loading;
    bit          m_armed;
    bit          m_err;
    bit          m_locked;
    int          m_fails;
    logic [17:0] m_key;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_obs();
        return {11'd0, bus.key_busy, bus.key_armed, bus.key_err, bus.key_x, bus.key_p};
    endfunction

    function automatic logic [31:0] pack_exp();
        logic [17:0] k;
        k = m_armed ? m_key : 18'd0;
        return {11'd0, m_loading, m_armed, m_err, k};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_loading = 1'b0;
        m_armed   = 1'b0;
        m_err     = 1'b0;
        m_locked  = 1'b0;
        m_fails   = 0;
        m_key     = '0;
    endtask

    function automatic logic [17:0] q_key();
        logic [17:0] k;
        k = '0;
        for (int i = 0; i < 18; i++) k = {k[16:0], m_q[i]};
        return k;
    endfunction

    task automatic model_update(input bit start, input bit vld, input bit sdi);
        int ones;
        if (start && !m_locked) begin
            m_q.delete();
            m_loading = 1'b1;
            m_armed   = 1'b0;
            m_err     = 1'b0;
        end else if (m_loading && vld) begin
            m_q.push_back(sdi);
            if (m_q.size() == 18 && !PARITY_ON) begin
                m_loading = 1'b0;
                m_armed   = 1'b1;
                m_key     = q_key();
            end else if (m_q.size() == 19) begin
                m_loading = 1'b0;
                ones = 0;
                foreach (m_q[i]) ones += int'(m_q[i]);
                if (ones % 2 == 0) begin
                    m_armed = 1'b1;
                    m_fails = 0;
                    m_key   = q_key();
                end else begin
                    m_err = 1'b1;
                    m_fails++;
                    if (m_fails >= 3) m_locked = 1'b1;
                end
            end
        end
    endtask

    // One clock: drive inputs, take the edge, update the model, compare everything 1 ns later.
    task automatic step(input string tag, input bit start, input bit vld, input bit sdi);
        bus.key_start   = start;
        bus.key_sdi_vld = vld;
        bus.key_sdi     = sdi;
        @(posedge clk);
        model_update(start, vld, sdi);
        #1;
        check(tag, pack_obs(), pack_exp());
        bus.key_start   = 1'b0;
        bus.key_sdi_vld = 1'b0;
        bus.key_sdi     = 1'b0;
    endtask

    task automatic send_word(input string tag, input logic [17:0] k, input int gap_max);
        int g;
        for (int i = 17; i >= 0; i--) begin
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 1)) : 0;
            for (int j = 0; j < g; j++) step(tag, 1'b0, 1'b0, 1'($urandom_range(1, 0)));
            step(tag, 1'b0, 1'b1, k[i]);
        end
    endtask

    // Asynchronous reset pulse in mid-cycle; outputs must clear before any further edge.
    task automatic pulse_reset(input string tag);
        bus.key_start   = 1'b0;
        bus.key_sdi_vld = 1'b0;
        bus.key_sdi     = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        check({tag, "_async"}, pack_obs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        rst_n           = 1'b0;
        bus.key_start   = 1'b0;
        bus.key_sdi_vld = 1'b0;
        bus.key_sdi     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", pack_obs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Valid bits while idle are ignored.
        step("idle_vld", 1'b0, 1'b1, 1'b1);
        step("idle_vld", 1'b0, 1'b1, 1'b0);

        // Back-to-back load of the reference key.
        step("load_start", 1'b1, 1'b0, 1'b0);
        send_word("load_bits", 18'h2B5C6, 0);
`ifdef KEY_PARITY_EN
        check("load_not_yet_armed", 32'(bus.key_armed), 32'd0);
        step("load_parity", 1'b0, 1'b1, 1'b0);
`endif
        check("load_key_x", 32'(bus.key_x), 32'h2B5C);
        check("load_key_p", 32'(bus.key_p), 32'h6);
        check("load_armed", 32'(bus.key_armed), 32'd1);
        step("armed_hold", 1'b0, 1'b1, 1'b1);

        // Start while armed clears the key on the next edge.
        step("armed_restart", 1'b1, 1'b0, 1'b0);
        check("armed_restart_x", 32'(bus.key_x), 32'd0);

        // Load with 1-3 cycle gaps between valid bits.
        send_word("gap_bits", 18'h2B5C6, 3);
`ifdef KEY_PARITY_EN
        step("gap_idle", 1'b0, 1'b0, 1'b0);
        check("gap_busy", 32'(bus.key_busy), 32'd1);
        step("gap_parity", 1'b0, 1'b1, 1'b0);
`endif
        check("gap_key", {14'd0, bus.key_x, bus.key_p}, 32'h2B5C6);

        // Start collides with the 10th bit: restart, bit dropped.
        step("coll_start", 1'b1, 1'b0, 1'b0);
        for (int i = 17; i >= 9; i--) step("coll_pre", 1'b0, 1'b1, 1'($urandom_range(1, 0)));
        step("coll_hit", 1'b1, 1'b1, 1'b1);
        check("coll_busy", 32'(bus.key_busy), 32'd1);
        send_word("coll_bits", 18'h15A3C, 0);
`ifdef KEY_PARITY_EN
        step("coll_parity", 1'b0, 1'b1, 1'(^18'h15A3C));
`endif
        check("coll_key", {14'd0, bus.key_x, bus.key_p}, 32'h15A3C);

        // Reset while armed, then reset at bit 9 of a load.
        pulse_reset("rst_armed");
        step("rst_idle_vld", 1'b0, 1'b1, 1'b1);
        step("rst9_start", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step("rst9_bits", 1'b0, 1'b1, 1'($urandom_range(1, 0)));
        pulse_reset("rst_bit9");
        step("rst9_idle_vld", 1'b0, 1'b1, 1'b0);

`ifdef KEY_PARITY_EN
        // Three bad-parity loads in a row lock the block out.
        for (int n = 0; n < 3; n++) begin
            step("bad_start", 1'b1, 1'b0, 1'b0);
            send_word("bad_bits", 18'h2B5C6, 0);
            step("bad_parity", 1'b0, 1'b1, 1'b1);
            check("bad_err", 32'(bus.key_err), 32'd1);
            check("bad_key_zero", {14'd0, bus.key_x, bus.key_p}, 32'd0);
        end
        step("lock_start", 1'b1, 1'b0, 1'b0);
        check("lock_err", 32'(bus.key_err), 32'd1);
        check("lock_busy", 32'(bus.key_busy), 32'd0);
        pulse_reset("lock_exit");
`else
        // All-ones key with parity disabled.
        step("ones_start", 1'b1, 1'b0, 1'b0);
        send_word("ones_bits", 18'h3FFFF, 0);
        check("ones_key_x", 32'(bus.key_x), 32'h3FFF);
        check("ones_key_p", 32'(bus.key_p), 32'hF);
        check("ones_armed", 32'(bus.key_armed), 32'd1);
        check("ones_err", 32'(bus.key_err), 32'd0);
`endif

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(299, 0) == 0 || (m_locked && $urandom_range(9, 0) == 0)) begin
                pulse_reset("rnd_rst");
            end else begin
                step("rnd",
                     m_loading ? ($urandom_range(79, 0) == 0) : ($urandom_range(5, 0) == 0),
                     ($urandom_range(2, 0) != 0),
                     1'($urandom_range(1, 0)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/key_loader.md
KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be asynchronous and active-low, as listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 key_start  input  1  one-cycle pulse that begins a new key load.
REQ-005 key_sdi  input  1  serial key data bit.
REQ-006 key_sdi_vld  input  1  key_sdi is valid and is consumed this cycle.
REQ-007 key_p  output  4  mux-lock keys; key_p[i] drives p(i+1) of the locked c432 netlist.
REQ-008 key_x  output  14  XOR-lock keys; key_x[i] drives X_(i+1) of the locked c432 netlist.
REQ-009 key_busy  output  1  high in SHIFT and CHECK.
REQ-010 key_armed  output  1  high in ARMED only.
REQ-011 key_err  output  1  high in ERROR and LOCKOUT.

Function
REQ-012 Key word K[17:0] SHALL arrive MSB first (K[17] first); the shift register SHALL be updated as sr <= {sr[16:0], key_sdi} on each accepted bit.
REQ-013 The block SHALL map key_x = K[17:4] and key_p = K[3:0].
REQ-014 FSM states SHALL be IDLE, SHIFT, CHECK, ARMED, ERROR and LOCKOUT; IDLE is the reset state.
REQ-015 key_start SHALL move any state except LOCKOUT to SHIFT, clear the 5-bit bit counter and clear sr.
REQ-016 In SHIFT, each cycle with key_sdi_vld=1 SHALL shift one bit and increment the counter; cycles with key_sdi_vld=0 SHALL hold state.
REQ-017 On acceptance of the 18th bit, the FSM SHALL go to CHECK if KEY_PARITY_EN is defined, otherwise to ARMED.
REQ-018 In CHECK, the next accepted bit SHALL be the parity bit; if the XOR of K[17:0] and the parity bit is 0, go to ARMED, else go to ERROR.
REQ-019 key_p and key_x SHALL be registered, equal K in ARMED, and equal 0 in all other states; key_armed SHALL rise the cycle after the final bit (data or parity) is accepted.
REQ-020 If key_start and key_sdi_vld are high in the same cycle, key_start SHALL win and the bit SHALL be discarded.
REQ-021 key_start in ARMED SHALL clear key_p, key_x and key_armed on the next edge.
REQ-022 A 2-bit fail counter SHALL increment on every entry to ERROR and clear on every entry to ARMED.
REQ-023 The third consecutive ERROR SHALL enter LOCKOUT instead of ERROR; LOCKOUT SHALL ignore key_start and SHALL exit only on rst_n.
REQ-024 key_sdi_vld SHALL be ignored in IDLE, ARMED, ERROR and LOCKOUT.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, and SHALL force sr, the bit counter, the fail counter, key_p, key_x, key_busy, key_armed and key_err to 0, including mid-load.

Configuration
REQ-026 The macro KEY_PARITY_EN SHALL control parity checking.
REQ-027 With KEY_PARITY_EN defined, CHECK, ERROR, LOCKOUT and the fail counter SHALL be present.
REQ-028 Without KEY_PARITY_EN, CHECK, ERROR, LOCKOUT and the fail counter SHALL be removed, key_err SHALL be tied to 0, and ARMED SHALL follow the 18th bit directly.

Verification
REQ-029 Parity on: start, then bits of K=18'h2B5C6, then parity 0 -> key_x=14'h2B5C, key_p=4'h6, and key_armed=1 one cycle after the parity bit.
REQ-030 Parity on: same K with parity 1 -> key_err=1 and key_p/key_x stay 0; three such loads -> LOCKOUT, and a further key_start leaves key_err=1 and key_busy=0.
REQ-031 Load K=18'h2B5C6 with key_sdi_vld gaps of 1-3 cycles -> same result as REQ-029; key_busy=1 throughout the load.
REQ-032 Assert key_start together with key_sdi_vld at the 10th bit -> the load restarts, the bit is discarded, and the next 18 bits form K.
REQ-033 Pulse rst_n low at bit 9, and separately while ARMED -> all outputs 0 asynchronously and state IDLE.
REQ-034 Parity off: 18 bits of 18'h3FFFF -> key_x=14'h3FFF, key_p=4'hF, key_armed=1 the next cycle, and key_err=0 always.
